// File: rtl/arp_decode.sv
// arp_decode: parses the 28-byte ARP/IPv4-over-Ethernet body and reports accepted or rejected frames.
// Define ARP_DECODE_STRICT_EN to also require HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4.
module arp_decode #(
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter logic [31:0] IP_ADDR  = 32'hC0A8_0164
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        arp_decode_valid,
  input  logic        busy,
  input  logic        crc_err,
  output logic        arp_valid,
  output logic        arp_drop,
  output logic        arp_oper,
  output logic [47:0] arp_sha,
  output logic [31:0] arp_spa
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIELDS   = 2'd1,
    WAIT_EOF = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam logic [4:0] LAST_BYTE = 5'd27;

  state_e      state_q;
  logic [4:0]  byte_cnt_q;
  logic        valid_prev_q;

  logic [15:0] oper_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic [47:0] tha_q;
  logic [31:0] tpa_q;
`ifdef ARP_DECODE_STRICT_EN
  logic [15:0] htype_q;
  logic [15:0] ptype_q;
  logic [7:0]  hlen_q;
  logic [7:0]  plen_q;
`endif

  logic        arp_valid_q;
  logic        arp_drop_q;
  logic        arp_oper_q;
  logic [47:0] arp_sha_q;
  logic [31:0] arp_spa_q;

  logic        start_s;
  logic        capture_s;
  logic        frame_end_s;
  logic [4:0]  byte_idx_s;
  logic        addr_ok_s;
  logic        hdr_ok_s;
  logic        ok_s;

  // Byte capture qualification; a fresh rise of valid in WAIT_EOF ends the current frame
  always_comb begin
    start_s     = arp_decode_valid & ~valid_prev_q;
    byte_idx_s  = 5'd0;
    capture_s   = 1'b0;
    frame_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        byte_idx_s = 5'd0;
        capture_s  = start_s;
      end
      FIELDS: begin
        byte_idx_s = byte_cnt_q;
        capture_s  = arp_decode_valid;
      end
      WAIT_EOF: begin
        frame_end_s = ~busy | start_s;
      end
      default: begin
        capture_s = 1'b0;
      end
    endcase
  end

  // Acceptance decision evaluated at end of frame
  always_comb begin
    addr_ok_s = 1'b0;
    if (oper_q == 16'h0001) begin
      addr_ok_s = (tpa_q == IP_ADDR);
    end else if (oper_q == 16'h0002) begin
      addr_ok_s = (tha_q == MAC_ADDR);
    end else begin
      addr_ok_s = 1'b0;
    end
`ifdef ARP_DECODE_STRICT_EN
    hdr_ok_s = (htype_q == 16'h0001) && (ptype_q == 16'h0800) &&
               (hlen_q == 8'd6) && (plen_q == 8'd4);
`else
    hdr_ok_s = 1'b1;
`endif
    ok_s = ~crc_err & addr_ok_s & hdr_ok_s;
  end

  // Field shift registers, network byte order (MSB first)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oper_q  <= 16'h0;
      sha_q   <= 48'h0;
      spa_q   <= 32'h0;
      tha_q   <= 48'h0;
      tpa_q   <= 32'h0;
`ifdef ARP_DECODE_STRICT_EN
      htype_q <= 16'h0;
      ptype_q <= 16'h0;
      hlen_q  <= 8'h0;
      plen_q  <= 8'h0;
`endif
    end else if (capture_s) begin
`ifdef ARP_DECODE_STRICT_EN
      if (byte_idx_s <= 5'd1) begin
        htype_q <= {htype_q[7:0], rxd};
      end else if (byte_idx_s <= 5'd3) begin
        ptype_q <= {ptype_q[7:0], rxd};
      end else if (byte_idx_s == 5'd4) begin
        hlen_q <= rxd;
      end else if (byte_idx_s == 5'd5) begin
        plen_q <= rxd;
      end else
`endif
      if (byte_idx_s == 5'd6 || byte_idx_s == 5'd7) begin
        oper_q <= {oper_q[7:0], rxd};
      end else if (byte_idx_s >= 5'd8 && byte_idx_s <= 5'd13) begin
        sha_q <= {sha_q[39:0], rxd};
      end else if (byte_idx_s >= 5'd14 && byte_idx_s <= 5'd17) begin
        spa_q <= {spa_q[23:0], rxd};
      end else if (byte_idx_s >= 5'd18 && byte_idx_s <= 5'd23) begin
        tha_q <= {tha_q[39:0], rxd};
      end else if (byte_idx_s >= 5'd24 && byte_idx_s <= LAST_BYTE) begin
        tpa_q <= {tpa_q[23:0], rxd};
      end else begin
        oper_q <= oper_q;
      end
    end else begin
      oper_q <= oper_q;
    end
  end

  // Frame FSM with registered result pulses and held result fields.
  // valid_prev_q resets high so a frame already in flight at reset release is never picked up mid-stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 5'd0;
      valid_prev_q <= 1'b1;
      arp_valid_q  <= 1'b0;
      arp_drop_q   <= 1'b0;
      arp_oper_q   <= 1'b0;
      arp_sha_q    <= 48'h0;
      arp_spa_q    <= 32'h0;
    end else begin
      valid_prev_q <= arp_decode_valid;
      arp_valid_q  <= 1'b0;
      arp_drop_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_s) begin
            byte_cnt_q <= 5'd1;
            state_q    <= FIELDS;
          end else begin
            byte_cnt_q <= 5'd0;
          end
        end
        FIELDS: begin
          if (arp_decode_valid) begin
            byte_cnt_q <= byte_cnt_q + 5'd1;
            if (byte_cnt_q == LAST_BYTE) begin
              state_q <= WAIT_EOF;
            end else begin
              state_q <= FIELDS;
            end
          end else begin
            arp_drop_q <= 1'b1;
            byte_cnt_q <= 5'd0;
            state_q    <= DROP;
          end
        end
        WAIT_EOF: begin
          if (frame_end_s) begin
            arp_valid_q <= ok_s;
            arp_drop_q  <= ~ok_s;
            if (ok_s) begin
              arp_oper_q <= (oper_q == 16'h0001);
              arp_sha_q  <= sha_q;
              arp_spa_q  <= spa_q;
            end else begin
              arp_oper_q <= arp_oper_q;
            end
            byte_cnt_q <= 5'd0;
            state_q    <= IDLE;
          end else begin
            state_q <= WAIT_EOF;
          end
        end
        DROP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arp_valid = arp_valid_q;
  assign arp_drop  = arp_drop_q;
  assign arp_oper  = arp_oper_q;
  assign arp_sha   = arp_sha_q;
  assign arp_spa   = arp_spa_q;

endmodule
